// File: rtl/start_stop_det.sv
`default_nettype none
// ============================================================================
// Module      : start_stop_det
// Description : I2C bus START / repeated START / STOP detector. Synchronizes
//               and glitch-filters the raw SDA/SCL lines, tracks bus-busy
//               state and emits filtered SCL edge strobes for a slave shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module start_stop_det #(
    parameter int SYNC_STAGES = 2,  // flops per synchronizer chain (2..4)
    parameter int FILTER_LEN  = 3   // cycles a new level must persist (1..15)
) (
    input  logic clk,
    input  logic rst,
    input  logic SDA_in,
    input  logic SCL_in,
    output logic start_found,
    output logic repeated_start,
    output logic stop_found,
    output logic bus_busy,
    output logic scl_rise,
    output logic scl_fall
);

    // Counter value at which the next increment would reach FILTER_LEN.
    localparam logic [3:0] c_filt_last = 4'(FILTER_LEN - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Line index 0 is SDA, index 1 is SCL.
    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {SCL_in, SDA_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic [SYNC_STAGES-1:0] r_sync;
            logic [3:0]             r_cnt;
            logic                   r_filt;
            logic                   w_synced;

            assign w_synced = r_sync[SYNC_STAGES-1];

            // Metastability chain; resets to the idle (high) bus level.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= '1;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
                end
            end

            // Accept a new level only after it persists FILTER_LEN cycles.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt  <= 4'd0;
                    r_filt <= 1'b1;
                end else if (w_synced == r_filt) begin
                    r_cnt <= 4'd0;
                end else if (r_cnt == c_filt_last) begin
                    r_filt <= w_synced;
                    r_cnt  <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end

            assign w_filt[gi] = r_filt;
        end
    endgenerate

    logic   w_sda_f;
    logic   w_scl_f;
    logic   r_prev_sda;
    logic   r_prev_scl;
    logic   w_scl_hi;
    logic   w_start;
    logic   w_stop;
    state_t r_state;

    assign w_sda_f  = w_filt[0];
    assign w_scl_f  = w_filt[1];
    // SCL must be high both before and after the SDA change; a simultaneous
    // SCL edge therefore suppresses START/STOP.
    assign w_scl_hi = r_prev_scl & w_scl_f;
    assign w_start  = r_prev_sda & ~w_sda_f & w_scl_hi;
    assign w_stop   = ~r_prev_sda & w_sda_f & w_scl_hi;

    // Edge history, bus-state FSM and registered one-cycle event strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_sda     <= 1'b1;
            r_prev_scl     <= 1'b1;
            r_state        <= S_IDLE;
            start_found    <= 1'b0;
            repeated_start <= 1'b0;
            stop_found     <= 1'b0;
            bus_busy       <= 1'b0;
            scl_rise       <= 1'b0;
            scl_fall       <= 1'b0;
        end else begin
            r_prev_sda     <= w_sda_f;
            r_prev_scl     <= w_scl_f;
            start_found    <= w_start;
            repeated_start <= w_start & (r_state == S_BUSY);
            stop_found     <= w_stop;
            scl_rise       <= ~r_prev_scl & w_scl_f;
            scl_fall       <= r_prev_scl & ~w_scl_f;
            case (r_state)
                S_IDLE: begin
                    // A STOP seen while idle is still strobed but changes nothing.
                    if (w_start) begin
                        r_state  <= S_BUSY;
                        bus_busy <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (w_stop) begin
                        r_state  <= S_IDLE;
                        bus_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
